// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: merges the in-order writeback stream with
// buffered multi-cycle results and keeps a busy scoreboard for outstanding results.
module wb_write_arbiter #(
   parameter int REG_SIZE   = 32,
   parameter int NO_OF_REGS = 32,
   parameter int REGW       = $clog2(NO_OF_REGS),
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_LIM = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  pipe_we_i,
   input  logic [REGW-1:0]       pipe_waddr_i,
   input  logic [REG_SIZE-1:0]   pipe_wdata_i,
   output logic                  pipe_stall_o,
   input  logic                  iss_valid_i,
   input  logic [REGW-1:0]       iss_waddr_i,
   input  logic                  mc_valid_i,
   output logic                  mc_ready_o,
   input  logic [REGW-1:0]       mc_waddr_i,
   input  logic [REG_SIZE-1:0]   mc_wdata_i,
   output logic [NO_OF_REGS-1:0] busy_o,
   output logic                  we_o,
   output logic [REGW-1:0]       waddr_o,
   output logic [REG_SIZE-1:0]   wdata_o
);

   localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNTW = $clog2(FIFO_DEPTH + 1);
   localparam int STW  = $clog2(STARVE_LIM + 1);
   localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);
   localparam logic [STW-1:0]  LIM_C   = STW'(STARVE_LIM);

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_PIPE,
      SEL_FIFO,
      SEL_STARVE
   } sel_e;

   logic [REGW-1:0]       q_addr [FIFO_DEPTH];
   logic [REG_SIZE-1:0]   q_data [FIFO_DEPTH];
   logic [PTRW-1:0]       rd_ptr, wr_ptr;
   logic [CNTW-1:0]       count, count_next;
   logic [STW-1:0]        starve_cnt, starve_next;
   logic [NO_OF_REGS-1:0] busy_q, busy_next;
   logic                  fifo_empty;
   logic                  pipe_wr;
   logic                  push;
   logic                  pop;
   logic [REGW-1:0]       head_addr;
   logic [REG_SIZE-1:0]   head_data;
   sel_e                  sel;

   // Handshake: a result transfers on a cycle where mc_valid_i && mc_ready_o.
   // mc_ready_o depends only on the current fill level, never on a same-cycle pop.
   assign fifo_empty   = (count == '0);
   assign mc_ready_o   = (count < DEPTH_C);
   assign pipe_wr      = pipe_we_i && (pipe_waddr_i != '0);
   assign push         = mc_valid_i && mc_ready_o && (mc_waddr_i != '0);
   assign pipe_stall_o = !fifo_empty && (starve_cnt == LIM_C);
   assign head_addr    = q_addr[rd_ptr];
   assign head_data    = q_data[rd_ptr];
   assign busy_o       = busy_q;

   always_comb begin
      sel = SEL_NONE;
      if (pipe_stall_o) begin
         sel = SEL_STARVE;
      end else if (pipe_wr) begin
         sel = SEL_PIPE;
      end else if (!fifo_empty) begin
         sel = SEL_FIFO;
      end
   end

   assign pop = (sel == SEL_STARVE) || (sel == SEL_FIFO);

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNTW'(1);
         2'b01:   count_next = count - CNTW'(1);
         default: count_next = count;
      endcase
   end

   // The counter only measures how long a waiting head has been blocked.
   always_comb begin
      starve_next = starve_cnt;
      if (pop || fifo_empty) begin
         starve_next = '0;
      end else if ((sel == SEL_PIPE) && (starve_cnt != LIM_C)) begin
         starve_next = starve_cnt + STW'(1);
      end
   end

   // Clear first so an issue to the same register in the same cycle wins.
   always_comb begin
      busy_next = busy_q;
      if (pop) begin
         busy_next[head_addr] = 1'b0;
      end
      if (iss_valid_i && (iss_waddr_i != '0)) begin
         busy_next[iss_waddr_i] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         q_addr[wr_ptr] <= mc_waddr_i;
         q_data[wr_ptr] <= mc_wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
         busy_q     <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTRW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTRW'(1);
         end
         count      <= count_next;
         starve_cnt <= starve_next;
         busy_q     <= busy_next;
      end
   end

   // Address/data hold their last value on idle cycles; only we_o drops.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_o    <= 1'b0;
         waddr_o <= '0;
         wdata_o <= '0;
      end else begin
         we_o <= (sel != SEL_NONE);
         if (pop) begin
            waddr_o <= head_addr;
            wdata_o <= head_data;
         end else if (sel == SEL_PIPE) begin
            waddr_o <= pipe_waddr_i;
            wdata_o <= pipe_wdata_i;
         end
      end
   end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios followed by
// random traffic, compared cycle by cycle against a queue-based reference model.
module tb_wb_write_arbiter;

   localparam int REG_SIZE   = 32;
   localparam int NO_OF_REGS = 32;
   localparam int REGW       = 5;
   localparam int FIFO_DEPTH = 2;
   localparam int STARVE_LIM = 4;

   logic                  clk_i = 1'b0;
   logic                  rst_ni = 1'b0;
   logic                  pipe_we_i = 1'b0;
   logic [REGW-1:0]       pipe_waddr_i = '0;
   logic [REG_SIZE-1:0]   pipe_wdata_i = '0;
   logic                  pipe_stall_o;
   logic                  iss_valid_i = 1'b0;
   logic [REGW-1:0]       iss_waddr_i = '0;
   logic                  mc_valid_i = 1'b0;
   logic                  mc_ready_o;
   logic [REGW-1:0]       mc_waddr_i = '0;
   logic [REG_SIZE-1:0]   mc_wdata_i = '0;
   logic [NO_OF_REGS-1:0] busy_o;
   logic                  we_o;
   logic [REGW-1:0]       waddr_o;
   logic [REG_SIZE-1:0]   wdata_o;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [REGW+REG_SIZE-1:0] exp_q[$];
   logic [NO_OF_REGS-1:0]    m_busy;
   int                       m_cnt;
   logic                     m_we;
   logic [REGW-1:0]          m_waddr;
   logic [REG_SIZE-1:0]      m_wdata;

   wb_write_arbiter #(
      .REG_SIZE(REG_SIZE), .NO_OF_REGS(NO_OF_REGS), .REGW(REGW),
      .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIM(STARVE_LIM)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
      .pipe_stall_o(pipe_stall_o),
      .iss_valid_i(iss_valid_i), .iss_waddr_i(iss_waddr_i),
      .mc_valid_i(mc_valid_i), .mc_ready_o(mc_ready_o),
      .mc_waddr_i(mc_waddr_i), .mc_wdata_i(mc_wdata_i),
      .busy_o(busy_o), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_busy  = '0;
      m_cnt   = 0;
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
   endtask

   // One clock: drive at negedge, check handshake outputs, advance model, check registers.
   task automatic step(input logic pwe, input logic [REGW-1:0] pa, input logic [REG_SIZE-1:0] pd,
                       input logic iv, input logic [REGW-1:0] ia,
                       input logic mv, input logic [REGW-1:0] ma, input logic [REG_SIZE-1:0] md);
      logic ready, stall;
      logic [REGW+REG_SIZE-1:0] head;
      @(negedge clk_i);
      pipe_we_i = pwe; pipe_waddr_i = pa; pipe_wdata_i = pd;
      iss_valid_i = iv; iss_waddr_i = ia;
      mc_valid_i = mv; mc_waddr_i = ma; mc_wdata_i = md;
      #1;
      ready = (exp_q.size() < FIFO_DEPTH);
      stall = (exp_q.size() > 0) && (m_cnt == STARVE_LIM);
      check("mc_ready", 64'(mc_ready_o), 64'(ready));
      check("pipe_stall", 64'(pipe_stall_o), 64'(stall));
      if (stall || (!(pwe && pa != 0) && exp_q.size() > 0)) begin
         head = exp_q.pop_front();
         m_we = 1'b1;
         m_waddr = head[REGW+REG_SIZE-1:REG_SIZE];
         m_wdata = head[REG_SIZE-1:0];
         m_busy[m_waddr] = 1'b0;
         m_cnt = 0;
      end else if (pwe && pa != 0) begin
         m_we = 1'b1; m_waddr = pa; m_wdata = pd;
         if (exp_q.size() > 0) m_cnt = (m_cnt < STARVE_LIM) ? m_cnt + 1 : STARVE_LIM;
         else m_cnt = 0;
      end else begin
         m_we = 1'b0;
         m_cnt = 0;
      end
      if (mv && ready && ma != 0) exp_q.push_back({ma, md});
      if (iv && ia != 0) m_busy[ia] = 1'b1;
      m_busy[0] = 1'b0;
      @(posedge clk_i);
      #1;
      check("we", 64'(we_o), 64'(m_we));
      check("waddr", 64'(waddr_o), 64'(m_waddr));
      check("wdata", 64'(wdata_o), 64'(m_wdata));
      check("busy", 64'(busy_o), 64'(m_busy));
   endtask

   task automatic idle();
      step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"}, 64'(we_o), 64'(0));
      check({tag, "_waddr"}, 64'(waddr_o), 64'(0));
      check({tag, "_wdata"}, 64'(wdata_o), 64'(0));
      check({tag, "_busy"}, 64'(busy_o), 64'(0));
      check({tag, "_ready"}, 64'(mc_ready_o), 64'(1));
      check({tag, "_stall"}, 64'(pipe_stall_o), 64'(0));
   endtask

   initial begin
      logic pwe, iv, mv;
      logic [REGW-1:0] pa, ia, ma;

      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      check_reset_outputs("reset");
      @(negedge clk_i);
      rst_ni = 1'b1;
      idle();
      idle();

      // pipeline write, then a dropped write to x0
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, '0, '0);
      check("pipe_x5_data", 64'(wdata_o), 64'hDEADBEEF);
      step(1'b1, 5'd0, 32'h11111111, 1'b0, '0, 1'b0, '0, '0);
      check("pipe_x0_we", 64'(we_o), 64'(0));

      // issue x7, return result with pipeline idle
      step(1'b0, '0, '0, 1'b1, 5'd7, 1'b0, '0, '0);
      check("busy7_set", 64'(busy_o[7]), 64'(1));
      step(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd7, 32'h1234);
      check("busy7_hold", 64'(busy_o[7]), 64'(1));
      idle();
      check("drain7_we", 64'(we_o), 64'(1));
      check("drain7_addr", 64'(waddr_o), 64'(7));
      check("drain7_data", 64'(wdata_o), 64'h1234);
      check("busy7_clr", 64'(busy_o[7]), 64'(0));

      // starvation: two pushes under continuous pipeline writes, third while full
      step(1'b0, '0, '0, 1'b1, 5'd9, 1'b0, '0, '0);
      step(1'b0, '0, '0, 1'b1, 5'd10, 1'b0, '0, '0);
      step(1'b1, 5'd1, 32'hA0000001, 1'b1, 5'd11, 1'b1, 5'd9, 32'h99);
      step(1'b1, 5'd2, 32'hA0000002, 1'b0, '0, 1'b1, 5'd10, 32'h1010);
      for (int i = 0; i < 3; i++) step(1'b1, 5'(3 + i), 32'hB0 + i, 1'b0, '0, 1'b0, '0, '0);
      step(1'b1, 5'd6, 32'hC6, 1'b0, '0, 1'b1, 5'd11, 32'h1111);
      check("starve_pop_addr", 64'(waddr_o), 64'(9));
      step(1'b1, 5'd6, 32'hC6, 1'b0, '0, 1'b1, 5'd11, 32'h1111);
      check("after_starve_pipe", 64'(waddr_o), 64'(6));
      for (int i = 0; i < 4; i++) idle();

      // asynchronous reset with queued results and busy x3
      step(1'b0, '0, '0, 1'b1, 5'd3, 1'b0, '0, '0);
      step(1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 1'b1, 5'd3, 32'h33);
      step(1'b1, 5'd2, 32'h2, 1'b0, '0, 1'b1, 5'd4, 32'h44);
      check("pre_reset_busy3", 64'(busy_o[3]), 64'(1));
      @(negedge clk_i);
      pipe_we_i = 1'b0; mc_valid_i = 1'b0; iss_valid_i = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 0; i < 4; i++) idle();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         pwe = ($urandom_range(0, 1) == 1);
         pa  = ($urandom_range(0, 7) == 0) ? '0 : REGW'($urandom_range(1, 31));
         iv  = ($urandom_range(0, 2) == 0);
         ia  = REGW'($urandom_range(0, 31));
         mv  = ($urandom_range(0, 4) < 2);
         ma  = ($urandom_range(0, 7) == 0) ? '0 : REGW'($urandom_range(1, 31));
         step(pwe, pa, $urandom, iv, ia, mv, ma, $urandom);
      end
      for (int i = 0; i < 4; i++) idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
